dm_port_arbiter: RTL

Two-master arbiter for the single data-memory port. The MEM-stage load/store path and an auxiliary master (DMA/debug loader) share one memory with one-cycle read latency. The block grants one master per cycle and drives the memory command from that master. It routes returned read data back to the owner and stalls the pipeline when the CPU loses arbitration. It sits between Stage_MEM's dm* outputs and the data memory.

---
 rtl/dm_port_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between the MEM-stage
// load/store path (CPU) and an auxiliary master (DMA/debug loader).
// The grant and the memory command are combinational. Read data returns one
// cycle after the grant and is steered to the master that issued the load.
module dm_port_arbiter #(
    parameter int BUS_W      = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    // CPU (MEM stage) master
    input  logic             cpuReq_in,
    input  logic             cpuWe_in,
    input  logic [BUS_W-1:0] cpuAddr_in,
    input  logic [3:0]       cpuBe_in,
    input  logic [BUS_W-1:0] cpuWData_in,
    output logic             cpuGnt_out,
    output logic             cpuStall_out,
    output logic             cpuRValid_out,
    output logic [BUS_W-1:0] cpuRData_out,
    // auxiliary (DMA/debug) master
    input  logic             dmaReq_in,
    input  logic             dmaWe_in,
    input  logic [BUS_W-1:0] dmaAddr_in,
    input  logic [3:0]       dmaBe_in,
    input  logic [BUS_W-1:0] dmaWData_in,
    input  logic             dmaLock_in,
    output logic             dmaGnt_out,
    output logic             dmaRValid_out,
    output logic [BUS_W-1:0] dmaRData_out,
    // data memory port
    output logic [BUS_W-1:0] dmAddr_out,
    output logic             dmWEn_out,
    output logic             dmREn_out,
    output logic [3:0]       dmDataW_out,
    output logic [BUS_W-1:0] dmWData_out,
    input  logic [BUS_W-1:0] dmRData_in
);

    typedef enum logic [1:0] {CPU_PRI, DMA_FORCE, DMA_LOCK} pri_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] LOCK_LIM   = 4'(LOCK_MAX);

    pri_t       pri, pri_next;
    owner_t     rd_owner, rd_owner_next;
    logic [3:0] starv, starv_next;
    logic [3:0] lockc, lockc_next;
    logic [3:0] starv_inc, lock_inc;
    logic       cpu_gnt, dma_gnt;

    assign starv_inc = starv + 4'd1;
    assign lock_inc  = lockc + 4'd1;

    // Grant selection: priority owner wins a contested cycle; nothing granted in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            if (pri == CPU_PRI) begin
                cpu_gnt = cpuReq_in;
                dma_gnt = dmaReq_in & ~cpuReq_in;
            end else begin
                dma_gnt = dmaReq_in;
                cpu_gnt = cpuReq_in & ~dmaReq_in;
            end
        end
    end

    // Priority FSM next state plus starvation/lock counters.
    always_comb begin
        pri_next   = pri;
        starv_next = starv;
        lockc_next = lockc;

        // Starvation only accumulates over contested CPU wins.
        if (dma_gnt || !dmaReq_in)
            starv_next = 4'd0;
        else if (cpu_gnt)
            starv_next = starv_inc;

        case (pri)
            CPU_PRI: begin
                if (cpu_gnt && dmaReq_in && starv_inc >= STARVE_LIM) begin
                    pri_next   = DMA_FORCE;
                    starv_next = 4'd0;
                end else if (dma_gnt && dmaLock_in) begin
                    pri_next   = DMA_LOCK;
                    lockc_next = 4'd0;
                end
            end
            DMA_FORCE: begin
                // Held until the forced grant is actually taken.
                if (dma_gnt) begin
                    pri_next   = dmaLock_in ? DMA_LOCK : CPU_PRI;
                    lockc_next = 4'd0;
                end else if (!dmaReq_in) begin
                    pri_next = CPU_PRI;
                end
            end
            DMA_LOCK: begin
                if (dma_gnt && dmaLock_in && lock_inc < LOCK_LIM) begin
                    lockc_next = lock_inc;
                end else begin
                    // Lock dropped, DMA idle, or burst limit: CPU gets a priority cycle.
                    pri_next   = CPU_PRI;
                    lockc_next = 4'd0;
                end
            end
            default: begin
                pri_next   = CPU_PRI;
                lockc_next = 4'd0;
            end
        endcase
    end

    // Owner of the load issued this cycle; data comes back next cycle.
    always_comb begin
        rd_owner_next = OWN_NONE;
        if (cpu_gnt && !cpuWe_in)
            rd_owner_next = OWN_CPU;
        else if (dma_gnt && !dmaWe_in)
            rd_owner_next = OWN_DMA;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri      <= CPU_PRI;
            starv    <= 4'd0;
            lockc    <= 4'd0;
            rd_owner <= OWN_NONE;
        end else begin
            pri      <= pri_next;
            starv    <= starv_next;
            lockc    <= lockc_next;
            rd_owner <= rd_owner_next;
        end
    end

    // Memory command and read-return steering.
    always_comb begin
        cpuGnt_out   = cpu_gnt;
        dmaGnt_out   = dma_gnt;
        cpuStall_out = cpuReq_in & ~cpu_gnt;

        dmAddr_out  = '0;
        dmWEn_out   = 1'b0;
        dmREn_out   = 1'b0;
        dmDataW_out = 4'd0;
        dmWData_out = '0;
        if (cpu_gnt) begin
            dmAddr_out  = cpuAddr_in;
            dmWEn_out   = cpuWe_in;
            dmREn_out   = ~cpuWe_in;
            dmDataW_out = cpuBe_in;
            dmWData_out = cpuWData_in;
        end else if (dma_gnt) begin
            dmAddr_out  = dmaAddr_in;
            dmWEn_out   = dmaWe_in;
            dmREn_out   = ~dmaWe_in;
            dmDataW_out = dmaBe_in;
            dmWData_out = dmaWData_in;
        end

        // A load whose return cycle coincides with reset is discarded.
        cpuRValid_out = ~rst && (rd_owner == OWN_CPU);
        dmaRValid_out = ~rst && (rd_owner == OWN_DMA);
        cpuRData_out  = cpuRValid_out ? dmRData_in : '0;
        dmaRData_out  = dmaRValid_out ? dmRData_in : '0;
    end

endmodule
